seg_dynamic_scan: RTL

- Six-digit dynamic-scan driver for the 7-segment display.
- Takes a 20-bit binary value, a per-digit decimal-point mask and a sign flag.
- Converts the value to BCD with a sequential shift-add-3 engine, then time-multiplexes the digits.
- Produces the sel[5:0]/seg[7:0] pair that feeds the 74HC595 serialiser directly downstream.

---
 rtl/seg_dynamic_scan.sv | 298 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/seg_dynamic_scan.sv
// -----------------------------------------------------------------------------
// seg_dynamic_scan
//
// Six-digit dynamic-scan driver for a 7-segment display. A 20-bit unsigned
// value (clamped to 999999) is converted to six BCD digits by a sequential
// shift-add-3 (double-dabble) engine that runs continuously. The digits are
// then time-multiplexed, one digit per scan slot of CNT_MAX+1 clocks.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   defined   : leading zeros are blanked and the sign is shown as a minus
//               on the first blank digit above the value.
//   undefined : all six digits always show their nibble; sign is ignored.
//   The decimal-point handling is the same in both builds.
//
// Parameters
//   CNT_MAX   : scan-slot counter terminal value (slot = CNT_MAX+1 clocks)
//   CONV_BITS : binary input width and double-dabble iteration count (20)
//
// Ports
//   sys_clk  in   system clock, rising edge
//   sys_rst  in   asynchronous reset, active-high
//   data     in   [CONV_BITS-1:0] unsigned value to display
//   point    in   [5:0] decimal-point mask, point[i] lights dp of digit i
//   sign     in   1 = show a minus sign
//   seg_en   in   1 = display on, 0 = blank
//   sel      out  [5:0] one-hot active-high digit select, sel[0] rightmost
//   seg      out  [7:0] active-low segments {dp,g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg_dynamic_scan #(
  parameter int CNT_MAX   = 49999,
  parameter int CONV_BITS = 20
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [CONV_BITS-1:0] data,
  input  logic [5:0]           point,
  input  logic                 sign,
  input  logic                 seg_en,
  output logic [5:0]           sel,
  output logic [7:0]           seg
);

  localparam int BCD_W = 24;
  localparam int CNT_W = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam int IT_W  = $clog2(CONV_BITS);

  localparam logic [CONV_BITS-1:0] DATA_LIMIT = CONV_BITS'(999999);
  localparam logic [IT_W-1:0]      ITER_LAST  = IT_W'(CONV_BITS - 1);
  localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(CNT_MAX);

  // One double-dabble correction: every nibble >= 5 gets +3 so that the
  // following left shift carries correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int k = 0; k < BCD_W / 4; k++) begin
      if (b[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = b[4*k +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // BCD nibble to active-low segment pattern, dp off.
  function automatic logic [7:0] seg_encode(input logic [3:0] n);
    logic [7:0] r;
    case (n)
      4'd0:    r = 8'hC0;
      4'd1:    r = 8'hF9;
      4'd2:    r = 8'hA4;
      4'd3:    r = 8'hB0;
      4'd4:    r = 8'h99;
      4'd5:    r = 8'h92;
      4'd6:    r = 8'h82;
      4'd7:    r = 8'hF8;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h90;
      default: r = 8'hFF;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Converter FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } conv_state_t;

  conv_state_t state_q, state_d;
  logic        load_en, shift_en, done_en;

  logic [CONV_BITS-1:0] cap_q, cap_d;
  logic [BCD_W-1:0]     shadow_q, shadow_d;
  logic [IT_W-1:0]      iter_q, iter_d;
  logic [CONV_BITS-1:0] data_clamped;
  logic [BCD_W-1:0]     shadow_adj;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    load_en  = 1'b0;
    shift_en = 1'b0;
    done_en  = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_LOAD;
      S_LOAD: begin
        load_en = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        if (iter_q == ITER_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_en = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign data_clamped = (data > DATA_LIMIT) ? DATA_LIMIT : data;
  assign shadow_adj   = dabble_adjust(shadow_q);

  always_comb begin
    cap_d    = cap_q;
    shadow_d = shadow_q;
    iter_d   = iter_q;
    if (load_en) begin
      cap_d    = data_clamped;
      shadow_d = '0;
      iter_d   = '0;
    end else if (shift_en) begin
      // MSB of the captured value enters the BCD shadow each iteration.
      shadow_d = {shadow_adj[BCD_W-2:0], cap_q[CONV_BITS-1]};
      cap_d    = {cap_q[CONV_BITS-2:0], 1'b0};
      iter_d   = iter_q + IT_W'(1);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cap_q    <= '0;
      shadow_q <= '0;
      iter_q   <= '0;
    end else begin
      cap_q    <= cap_d;
      shadow_q <= shadow_d;
      iter_q   <= iter_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Display register: value, sign and points change together on DONE so the
  // scan never shows a mix of old and new content.
  // ---------------------------------------------------------------------------
  logic [BCD_W-1:0] disp_bcd_q;
  logic [5:0]       disp_point_q;
  logic             disp_sign_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      disp_bcd_q   <= '0;
      disp_point_q <= '0;
      disp_sign_q  <= 1'b0;
    end else if (done_en) begin
      disp_bcd_q   <= shadow_q;
      disp_point_q <= point;
      disp_sign_q  <= sign;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan counter and digit index
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             cnt_last;

  assign cnt_last = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_last) begin
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit content for the current index
  // ---------------------------------------------------------------------------
  logic [3:0] cur_nib;
  logic       cur_pt;
  logic [5:0] cur_onehot;
  logic [7:0] cur_digit;

  always_comb begin
    cur_nib    = 4'd0;
    cur_pt     = 1'b0;
    cur_onehot = 6'b000000;
    case (idx_q)
      3'd0: begin cur_nib = disp_bcd_q[3:0];   cur_pt = disp_point_q[0]; cur_onehot = 6'b000001; end
      3'd1: begin cur_nib = disp_bcd_q[7:4];   cur_pt = disp_point_q[1]; cur_onehot = 6'b000010; end
      3'd2: begin cur_nib = disp_bcd_q[11:8];  cur_pt = disp_point_q[2]; cur_onehot = 6'b000100; end
      3'd3: begin cur_nib = disp_bcd_q[15:12]; cur_pt = disp_point_q[3]; cur_onehot = 6'b001000; end
      3'd4: begin cur_nib = disp_bcd_q[19:16]; cur_pt = disp_point_q[4]; cur_onehot = 6'b010000; end
      3'd5: begin cur_nib = disp_bcd_q[23:20]; cur_pt = disp_point_q[5]; cur_onehot = 6'b100000; end
      default: ;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Highest digit that must stay visible: the top nonzero nibble or the top
  // lit decimal point, whichever is higher; digit 0 always shows.
  logic [2:0] lead_k;

  always_comb begin
    lead_k = 3'd0;
    for (int k = 0; k < 6; k++) begin
      if ((disp_bcd_q[4*k +: 4] != 4'd0) || disp_point_q[k]) begin
        lead_k = 3'(k);
      end
    end
  end

  always_comb begin
    cur_digit = seg_encode(cur_nib);
    if (cur_pt) begin
      cur_digit[7] = 1'b0;
    end
    if (idx_q > lead_k) begin
      // lead_k = 5 never matches here, so the sign silently drops.
      if (disp_sign_q && (idx_q == lead_k + 3'd1)) begin
        cur_digit = 8'hBF;
      end else begin
        cur_digit = {~cur_pt, 7'h7F};
      end
    end
  end
`else
  logic sign_unused;
  assign sign_unused = disp_sign_q;

  always_comb begin
    cur_digit = seg_encode(cur_nib);
    if (cur_pt) begin
      cur_digit[7] = 1'b0;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Output register: sel and seg always change on the same edge
  // ---------------------------------------------------------------------------
  logic [5:0] sel_q, sel_d;
  logic [7:0] seg_q, seg_d;

  assign sel_d = seg_en ? cur_onehot : 6'b000000;
  assign seg_d = seg_en ? cur_digit  : 8'hFF;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sel_q <= 6'b000000;
      seg_q <= 8'hFF;
    end else begin
      sel_q <= sel_d;
      seg_q <= seg_d;
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;

endmodule
